// File: rtl/instr_fetch_unit.sv
// Fetch sequencer: steps the PC, reads instruction memory and hands each
// instruction to the decoder over a valid/ready handshake. Jumps reload the PC
// and discard any fetch that is still in flight.
module instr_fetch_unit #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned INSTR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  pcIn,
    output logic                   pcIncEn,
    output logic                   pcWrEn,
    output logic [ADDR_WIDTH-1:0]  pcWrData,
    output logic [ADDR_WIDTH-1:0]  memAddr,
    output logic                   memRdEn,
    input  logic [INSTR_WIDTH-1:0] memData,
    input  logic                   memValid,
    input  logic                   stall,
    input  logic                   jumpEn,
    input  logic [ADDR_WIDTH-1:0]  jumpAddr,
    output logic [INSTR_WIDTH-1:0] instrOut,
    output logic                   instrValid,
    input  logic                   instrReady,
    output logic [15:0]            fetchCount
);
    localparam int unsigned COUNT_WIDTH = 16;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;

    state_t                   state;
    state_t                   stateNext;
    logic                     handshake;
    logic [ADDR_WIDTH-1:0]    pcAhead;

    logic                     pcIncEnNxt;
    logic                     pcWrEnNxt;
    logic [ADDR_WIDTH-1:0]    pcWrDataNxt;
    logic [ADDR_WIDTH-1:0]    memAddrNxt;
    logic                     memRdEnNxt;
    logic [INSTR_WIDTH-1:0]   instrOutNxt;
    logic                     instrValidNxt;
    logic [COUNT_WIDTH-1:0]   fetchCountNxt;

    assign handshake = (state == HOLD) && instrValid && instrReady;

    // PC as it will read next cycle: a load or increment strobe issued this
    // cycle has not reached pcIn yet, so the next request address must include it
    assign pcAhead = pcWrEn  ? pcWrData :
                     pcIncEn ? pcIn + ADDR_WIDTH'(1) : pcIn;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pcIncEn    <= 1'b0;
            pcWrEn     <= 1'b0;
            pcWrData   <= '0;
            memAddr    <= '0;
            memRdEn    <= 1'b0;
            instrOut   <= '0;
            instrValid <= 1'b0;
            fetchCount <= '0;
        end else begin
            state      <= stateNext;
            pcIncEn    <= pcIncEnNxt;
            pcWrEn     <= pcWrEnNxt;
            pcWrData   <= pcWrDataNxt;
            memAddr    <= memAddrNxt;
            memRdEn    <= memRdEnNxt;
            instrOut   <= instrOutNxt;
            instrValid <= instrValidNxt;
            fetchCount <= fetchCountNxt;
        end
    end

    // Next state; a jump overrides every other transition
    always_comb begin
        stateNext = state;
        if (jumpEn) begin
            case (state)
                REQ:         stateNext = DRAIN;
                WAIT, DRAIN: stateNext = memValid ? IDLE : DRAIN;
                default:     stateNext = IDLE;
            endcase
        end else begin
            case (state)
                IDLE:    if (!stall) stateNext = REQ;
                REQ:     stateNext = WAIT;
                WAIT:    if (memValid) stateNext = HOLD;
                HOLD:    if (handshake) stateNext = stall ? IDLE : REQ;
                DRAIN:   if (memValid) stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs
    always_comb begin
        pcIncEnNxt    = 1'b0;
        pcWrEnNxt     = 1'b0;
        pcWrDataNxt   = pcWrData;
        memAddrNxt    = memAddr;
        memRdEnNxt    = 1'b0;
        instrOutNxt   = instrOut;
        instrValidNxt = instrValid;
        fetchCountNxt = fetchCount;
        if (jumpEn) begin
            pcWrEnNxt     = 1'b1;
            pcWrDataNxt   = jumpAddr;
            instrValidNxt = 1'b0;
        end else begin
            if (stateNext == REQ) begin
                memRdEnNxt = 1'b1;
                memAddrNxt = pcAhead;
            end
            if (state == WAIT && memValid) begin
                instrOutNxt   = memData;
                instrValidNxt = 1'b1;
                pcIncEnNxt    = 1'b1;
            end
            if (handshake) begin
                instrValidNxt = 1'b0;
                fetchCountNxt = fetchCount + COUNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by a randomized run
// checked against a transaction-level model of fetch/deliver/jump behaviour.
module tb_instr_fetch_unit;
    localparam int unsigned AW = 12;
    localparam int unsigned IW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pcIn;
    logic          pcIncEn;
    logic          pcWrEn;
    logic [AW-1:0] pcWrData;
    logic [AW-1:0] memAddr;
    logic          memRdEn;
    logic [IW-1:0] memData;
    logic          memValid;
    logic          stall;
    logic          jumpEn;
    logic [AW-1:0] jumpAddr;
    logic [IW-1:0] instrOut;
    logic          instrValid;
    logic          instrReady;
    logic [15:0]   fetchCount;

    instr_fetch_unit #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .pcIn(pcIn), .pcIncEn(pcIncEn), .pcWrEn(pcWrEn),
        .pcWrData(pcWrData), .memAddr(memAddr), .memRdEn(memRdEn), .memData(memData),
        .memValid(memValid), .stall(stall), .jumpEn(jumpEn), .jumpAddr(jumpAddr),
        .instrOut(instrOut), .instrValid(instrValid), .instrReady(instrReady),
        .fetchCount(fetchCount)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [IW-1:0] mem [0:(1<<AW)-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: the PC register (environment) follows the DUT strobes, then settle
    task automatic step();
        logic          inc;
        logic          wr;
        logic [AW-1:0] wd;
        inc = pcIncEn;
        wr  = pcWrEn;
        wd  = pcWrData;
        @(posedge clk);
        #1;
        if (wr) pcIn = wd;
        else if (inc) pcIn = pcIn + AW'(1);
    endtask

    task automatic doReset(input logic [AW-1:0] pc);
        rst = 1'b1; jumpEn = 1'b0; memValid = 1'b0; stall = 1'b0; instrReady = 1'b0;
        step(); step();
        rst = 1'b0;
        pcIn = pc;
    endtask

    // Called in a REQ cycle: memory answers one cycle later; returns in the first HOLD cycle
    task automatic respond(input logic [IW-1:0] d);
        step();
        memValid = 1'b1; memData = d;
        step();
        memValid = 1'b0;
    endtask

    // Randomized-phase model state
    logic          expInc, expWr, expValid, pending, killed, respNow, respKilled, busy;
    logic          deliver, hs;
    logic [AW-1:0] expWrData, pAddr;
    logic [IW-1:0] expOut;
    logic [15:0]   expCount;
    int            cnt;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = IW'($urandom);
        pcIn = '0; memData = '0; jumpAddr = '0; instrReady = 1'b0; stall = 1'b0;

        // 1: reset dominates memValid and jumpEn
        rst = 1'b1; memValid = 1'b1; jumpEn = 1'b1; jumpAddr = 12'h3FF; memData = 16'hFFFF;
        step(); step();
        chk("rst_pcIncEn", 32'(pcIncEn), 0);
        chk("rst_pcWrEn", 32'(pcWrEn), 0);
        chk("rst_pcWrData", 32'(pcWrData), 0);
        chk("rst_memAddr", 32'(memAddr), 0);
        chk("rst_memRdEn", 32'(memRdEn), 0);
        chk("rst_instrOut", 32'(instrOut), 0);
        chk("rst_instrValid", 32'(instrValid), 0);
        chk("rst_fetchCount", 32'(fetchCount), 0);

        // 2: basic best-case fetch
        doReset(12'h010);
        instrReady = 1'b1;
        step();
        chk("t2_req_rd", 32'(memRdEn), 1);
        chk("t2_req_addr", 32'(memAddr), 32'h010);
        respond(16'hA5C3);
        chk("t2_valid", 32'(instrValid), 1);
        chk("t2_instr", 32'(instrOut), 32'hA5C3);
        chk("t2_inc", 32'(pcIncEn), 1);
        chk("t2_cnt_before", 32'(fetchCount), 0);
        step();
        chk("t2_cnt", 32'(fetchCount), 1);
        chk("t2_inc_single", 32'(pcIncEn), 0);
        chk("t2_valid_drop", 32'(instrValid), 0);
        chk("t2_next_rd", 32'(memRdEn), 1);

        // 3: backpressure holds the instruction and blocks new fetches
        doReset(12'h010);
        step();
        chk("t3_addr", 32'(memAddr), 32'h010);
        respond(16'h5A5A);
        chk("t3_valid", 32'(instrValid), 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_hold_valid", 32'(instrValid), 1);
            chk("t3_hold_instr", 32'(instrOut), 32'h5A5A);
            chk("t3_hold_nord", 32'(memRdEn), 0);
            chk("t3_hold_noinc", 32'(pcIncEn), 0);
        end
        instrReady = 1'b1;
        step();
        chk("t3_next_rd", 32'(memRdEn), 1);
        chk("t3_next_addr", 32'(memAddr), 32'h011);
        chk("t3_cnt", 32'(fetchCount), 1);

        // 4: jump while waiting; the stale response is drained
        step();
        jumpEn = 1'b1; jumpAddr = 12'h200;
        step();
        jumpEn = 1'b0;
        chk("t4_wr", 32'(pcWrEn), 1);
        chk("t4_wrdata", 32'(pcWrData), 32'h200);
        chk("t4_noinc", 32'(pcIncEn), 0);
        chk("t4_novalid", 32'(instrValid), 0);
        memValid = 1'b1; memData = 16'hDEAD;
        step();
        memValid = 1'b0;
        chk("t4_stale_dropped", 32'(instrValid), 0);
        chk("t4_wr_single", 32'(pcWrEn), 0);
        chk("t4_nord", 32'(memRdEn), 0);
        step();
        chk("t4_rd", 32'(memRdEn), 1);
        chk("t4_addr", 32'(memAddr), 32'h200);
        chk("t4_cnt", 32'(fetchCount), 1);

        // 5: stall at handshake parks the sequencer
        respond(16'h7777);
        chk("t5_valid", 32'(instrValid), 1);
        stall = 1'b1;
        step();
        chk("t5_delivered", 32'(instrValid), 0);
        chk("t5_cnt", 32'(fetchCount), 2);
        chk("t5_nord0", 32'(memRdEn), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_stalled_nord", 32'(memRdEn), 0);
        end
        stall = 1'b0;
        step();
        chk("t5_rd", 32'(memRdEn), 1);
        chk("t5_addr", 32'(memAddr), 32'h201);

        // 6: jump in the handshake cycle drops the instruction
        respond(16'h8888);
        chk("t6_valid", 32'(instrValid), 1);
        jumpEn = 1'b1; jumpAddr = 12'h345;
        step();
        jumpEn = 1'b0;
        chk("t6_dropped", 32'(instrValid), 0);
        chk("t6_cnt", 32'(fetchCount), 2);
        chk("t6_wr", 32'(pcWrEn), 1);
        chk("t6_wrdata", 32'(pcWrData), 32'h345);
        chk("t6_noinc", 32'(pcIncEn), 0);
        step();
        chk("t6_rd", 32'(memRdEn), 1);
        chk("t6_addr", 32'(memAddr), 32'h345);

        // Randomized run against the transaction-level model
        doReset(AW'($urandom));
        expInc = 1'b0; expWr = 1'b0; expValid = 1'b0; expOut = '0; expCount = '0;
        expWrData = '0; pending = 1'b0; killed = 1'b0; pAddr = '0; cnt = 0;
        for (int c = 0; c < 4000; c++) begin
            busy = pending;
            respNow = 1'b0; respKilled = 1'b0;
            memValid = 1'b0; memData = IW'($urandom);
            if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    memValid = 1'b1; memData = mem[pAddr];
                    respNow = 1'b1; respKilled = killed; pending = 1'b0;
                end
            end
            if (memRdEn) begin
                chk("rnd_rd_addr", 32'(memAddr), 32'(pcIn));
                chk("rnd_rd_busy", 32'(busy || expValid), 0);
                pending = 1'b1; killed = 1'b0; pAddr = memAddr;
                cnt = int'($urandom_range(1, 3));
            end
            stall      = ($urandom_range(0, 3) == 0);
            instrReady = ($urandom_range(0, 2) != 0);
            jumpEn     = ($urandom_range(0, 19) == 0);
            jumpAddr   = AW'($urandom);
            if (jumpEn && pending) killed = 1'b1;

            deliver = respNow && !respKilled && !jumpEn;
            hs      = expValid && instrReady && !jumpEn;
            if (hs) expCount = expCount + 16'd1;
            expValid  = deliver || (expValid && !instrReady && !jumpEn);
            if (deliver) expOut = memData;
            expInc    = deliver;
            expWr     = jumpEn;
            expWrData = jumpAddr;

            step();
            chk("rnd_inc", 32'(pcIncEn), 32'(expInc));
            chk("rnd_wr", 32'(pcWrEn), 32'(expWr));
            if (expWr) chk("rnd_wrdata", 32'(pcWrData), 32'(expWrData));
            chk("rnd_valid", 32'(instrValid), 32'(expValid));
            if (expValid) chk("rnd_instr", 32'(instrOut), 32'(expOut));
            chk("rnd_cnt", 32'(fetchCount), 32'(expCount));
            chk("rnd_excl", 32'(pcIncEn && pcWrEn), 0);
        end
        chk("rnd_progress", 32'(fetchCount >= 16'd100), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
